// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot-product kernel: FSM encoding, lane
// geometry and the 32-bit saturation helper used on the result port.
package dot_product_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 2;
  localparam int WORD_W = LANE_W * LANES;
  // Sum of two LANE_W x LANE_W signed products needs one extra bit.
  localparam int PROD_W = 2 * LANE_W + 1;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    EMIT
  } state_t;

  localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  function automatic logic [WORD_W-1:0] sat32(input logic signed [63:0] acc);
    if (acc > SAT_MAX) begin
      return 32'h7FFF_FFFF;
    end else if (acc < SAT_MIN) begin
      return 32'h8000_0000;
    end
    return acc[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/dot_product_acc_if.sv
// ap_hs stream bundle between leaf_interface (master) and the dot-product
// kernel (slave): two input streams, two output streams and block control.
interface dot_product_acc_if;
  import dot_product_pkg::*;

  logic              ap_start;
  logic              ap_idle;
  logic              ap_ready;
  logic              ap_done;

  logic [WORD_W-1:0] Input_1_V_V;
  logic              Input_1_V_V_ap_vld;
  logic              Input_1_V_V_ap_ack;
  logic [WORD_W-1:0] Input_2_V_V;
  logic              Input_2_V_V_ap_vld;
  logic              Input_2_V_V_ap_ack;

  logic [WORD_W-1:0] Output_1_V_V;
  logic              Output_1_V_V_ap_vld;
  logic              Output_1_V_V_ap_ack;
  logic [WORD_W-1:0] Output_2_V_V;
  logic              Output_2_V_V_ap_vld;
  logic              Output_2_V_V_ap_ack;

  modport slave (
    input  ap_start,
    output ap_idle, ap_ready, ap_done,
    input  Input_1_V_V, Input_1_V_V_ap_vld,
    output Input_1_V_V_ap_ack,
    input  Input_2_V_V, Input_2_V_V_ap_vld,
    output Input_2_V_V_ap_ack,
    output Output_1_V_V, Output_1_V_V_ap_vld,
    input  Output_1_V_V_ap_ack,
    output Output_2_V_V, Output_2_V_V_ap_vld,
    input  Output_2_V_V_ap_ack
  );

  modport master (
    output ap_start,
    input  ap_idle, ap_ready, ap_done,
    output Input_1_V_V, Input_1_V_V_ap_vld,
    input  Input_1_V_V_ap_ack,
    output Input_2_V_V, Input_2_V_V_ap_vld,
    input  Input_2_V_V_ap_ack,
    input  Output_1_V_V, Output_1_V_V_ap_vld,
    output Output_1_V_V_ap_ack,
    input  Output_2_V_V, Output_2_V_V_ap_vld,
    output Output_2_V_V_ap_ack
  );

endinterface

// File: rtl/dot_mac.sv
// Two-lane signed multiply-accumulate: per-word lane products are summed and
// registered, then folded into a wide accumulator one cycle later.
module dot_mac
  import dot_product_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [WORD_W-1:0]       a,
  input  logic [WORD_W-1:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*LANE_W-1:0] lane_prod [LANES];
  logic signed [PROD_W-1:0]   prod_next;
  logic signed [PROD_W-1:0]   prod_reg;
  logic                       prod_vld_reg;
  logic signed [ACC_W-1:0]    acc_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_prod[gi] = (2*LANE_W)'($signed(a[gi*LANE_W +: LANE_W]))
                           * (2*LANE_W)'($signed(b[gi*LANE_W +: LANE_W]));
    end
  endgenerate

  assign prod_next = PROD_W'(lane_prod[1]) + PROD_W'(lane_prod[0]);

  // prod_reg is the registered pair product; prod_vld_reg tags it so the
  // accumulator only folds in products from accepted pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg     <= '0;
      prod_vld_reg <= 1'b0;
      acc_reg      <= '0;
    end else begin
      prod_vld_reg <= en;
      if (en) begin
        prod_reg <= prod_next;
      end
      if (clr) begin
        acc_reg <= '0;
      end else if (prod_vld_reg) begin
        acc_reg <= acc_reg + ACC_W'(prod_reg);
      end
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/dot_product_acc.sv
// Streaming dot-product kernel: accumulates VEC_LEN paired words per frame and
// emits a saturated result plus a frame index over ap_hs output ports.
module dot_product_acc
  import dot_product_pkg::*;
#(
  parameter int VEC_LEN = 64,
  parameter int ACC_W   = 40
) (
  input logic              ap_clk,
  input logic              ap_rst,
  dot_product_acc_if.slave bus
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [CNT_W-1:0]        pair_cnt_reg;
  logic [WORD_W-1:0]       frame_idx_reg;
  logic                    out1_vld_reg;
  logic                    out2_vld_reg;
  logic                    accept;
  logic                    last_pair;
  logic                    emit_done;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc;

  assign accept    = (state_reg == ACCUM) && bus.Input_1_V_V_ap_vld && bus.Input_2_V_V_ap_vld;
  assign last_pair = (pair_cnt_reg == CNT_W'(VEC_LEN - 1));
  // The frame completes when every output still pending is acked this cycle.
  assign emit_done = (state_reg == EMIT)
                   && (!out1_vld_reg || bus.Output_1_V_V_ap_ack)
                   && (!out2_vld_reg || bus.Output_2_V_V_ap_ack);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.ap_start) state_next = ACCUM;
      ACCUM:   if (accept && last_pair) state_next = DRAIN;
      DRAIN:   state_next = EMIT;
      EMIT:    if (emit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ap_idle            = (state_reg == IDLE);
    bus.Input_1_V_V_ap_ack = accept;
    bus.Input_2_V_V_ap_ack = accept;
    bus.ap_ready           = accept && last_pair;
    bus.ap_done            = emit_done;
    mac_clr                = (state_reg == IDLE) && bus.ap_start;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      pair_cnt_reg  <= '0;
      frame_idx_reg <= '0;
      out1_vld_reg  <= 1'b0;
      out2_vld_reg  <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        pair_cnt_reg <= '0;
      end else if (accept) begin
        pair_cnt_reg <= last_pair ? '0 : pair_cnt_reg + 1'b1;
      end

      if (emit_done) begin
        frame_idx_reg <= frame_idx_reg + 1'b1;
      end

      // Both outputs raise vld together; each one then retires on its own ack.
      if (state_reg == DRAIN) begin
        out1_vld_reg <= 1'b1;
        out2_vld_reg <= 1'b1;
      end else begin
        if (out1_vld_reg && bus.Output_1_V_V_ap_ack) out1_vld_reg <= 1'b0;
        if (out2_vld_reg && bus.Output_2_V_V_ap_ack) out2_vld_reg <= 1'b0;
      end
    end
  end

  dot_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (ap_clk),
    .rst (ap_rst),
    .clr (mac_clr),
    .en  (accept),
    .a   (bus.Input_1_V_V),
    .b   (bus.Input_2_V_V),
    .acc (acc)
  );

  // The accumulator is frozen from EMIT until the next frame clears it.
  assign bus.Output_1_V_V        = sat32(64'(acc));
  assign bus.Output_1_V_V_ap_vld = out1_vld_reg;
  assign bus.Output_2_V_V        = frame_idx_reg;
  assign bus.Output_2_V_V_ap_vld = out2_vld_reg;

endmodule
